// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sertx8_pkg.sv
// Shared definitions for the sertx8 parallel-to-serial transmitter:
// FSM state encoding, the default frame width and the bit-counter width
// helper used by the counter sub-module.
package gf180mcu_fd_sc_mcu9t5v0__sertx8_pkg;

    localparam int SERTX_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } sertx_state_t;

    // Bits needed to index WIDTH data bits (never less than one).
    function automatic int sertx_cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sertx8_cnt.sv
// Bit counter for the sertx8 transmitter.
// Tracks which data bit is currently on Q and flags the last data bit.
//   CLK     : rising-edge clock
//   RN      : asynchronous active-low reset
//   start_i : a word is being accepted this cycle (counter restarts at 0)
//   run_i   : transmitter is in the data-shift state
//   last_o  : the data bit on Q is the final one of the frame
module gf180mcu_fd_sc_mcu9t5v0__sertx8_cnt
    import gf180mcu_fd_sc_mcu9t5v0__sertx8_pkg::*;
#(
    parameter int WIDTH = SERTX_WIDTH_DEF
) (
    input  logic CLK,
    input  logic RN,
    input  logic start_i,
    input  logic run_i,
    output logic last_o
);

    localparam int            CW       = sertx_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Wraps to zero after the last bit so the next frame starts clean even
    // when it is followed by a parity cycle or by idle.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = run_i && (cnt_q == LAST_IDX);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sertx8.sv
// sertx8: parallel-to-serial transmitter with valid/ready intake.
// A word accepted on a clock edge appears on Q one bit per cycle starting
// right after that edge, with FRAME high while Q carries frame bits and an
// optional even-parity bit appended. Back-to-back words stream without gaps.
//   CLK   : rising-edge clock
//   RN    : asynchronous active-low reset
//   D     : parallel data word (sampled on handshake)
//   VALID : D holds a word to send
//   READY : a word can be accepted this cycle
//   Q     : serial data (registered)
//   FRAME : Q carries a frame bit (registered)
module gf180mcu_fd_sc_mcu9t5v0__sertx8
    import gf180mcu_fd_sc_mcu9t5v0__sertx8_pkg::*;
#(
    parameter int WIDTH     = SERTX_WIDTH_DEF,
    parameter int LSB_FIRST = 1,
    parameter int PARITY_EN = 0
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] D,
    input  logic             VALID,
    output logic             READY,
    output logic             Q,
    output logic             FRAME
);

    sertx_state_t     state_q;
    logic [WIDTH-1:0] sh_q;
    logic             par_q;
    logic             q_q;
    logic             frame_q;
    logic             last_bit;
    logic             hs;

    // Bit presented on Q for a given shift-register content.
    function automatic logic first_bit(input logic [WIDTH-1:0] v);
        return (LSB_FIRST != 0) ? v[0] : v[WIDTH-1];
    endfunction

    // Shift-register content after its leading bit has been sent.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
    endfunction

    gf180mcu_fd_sc_mcu9t5v0__sertx8_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .CLK     (CLK),
        .RN      (RN),
        .start_i (hs),
        .run_i   (state_q == ST_SHIFT),
        .last_o  (last_bit)
    );

    // READY depends only on registered state so VALID never loops back.
    assign READY = (state_q == ST_IDLE) || (state_q == ST_PAR) ||
                   (last_bit && (PARITY_EN == 0));
    assign hs    = VALID && READY;

    // The first bit goes straight to Q on the accepting edge; the shift
    // register keeps only the bits still to be sent.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            par_q   <= 1'b0;
            q_q     <= 1'b0;
            frame_q <= 1'b0;
        end else if (hs) begin
            state_q <= ST_SHIFT;
            q_q     <= first_bit(D);
            sh_q    <= advance(D);
            par_q   <= ^D;
            frame_q <= 1'b1;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (!last_bit) begin
                        q_q  <= first_bit(sh_q);
                        sh_q <= advance(sh_q);
                    end else if (PARITY_EN != 0) begin
                        state_q <= ST_PAR;
                        q_q     <= par_q;
                    end else begin
                        state_q <= ST_IDLE;
                        sh_q    <= '0;
                        q_q     <= 1'b0;
                        frame_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    sh_q    <= '0;
                    q_q     <= 1'b0;
                    frame_q <= 1'b0;
                end
            endcase
        end
    end

    assign Q     = q_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__sertx8.sv
module tb_gf180mcu_fd_sc_mcu9t5v0__sertx8;

    logic       CLK = 1'b0;
    logic       RN  = 1'b0;
    logic [7:0] D0  = 8'h00;
    logic [7:0] D1  = 8'h00;
    logic       V0  = 1'b0;
    logic       V1  = 1'b0;
    logic       READY0, Q0, FRAME0;
    logic       READY1, Q1, FRAME1;

    int checks = 0;
    int errors = 0;
    int rx_checks = 0;
    int rx_errors = 0;

    // dut0: defaults (LSB first, no parity); dut1: MSB first with parity
    logic [7:0] exp0_q[$];
    logic [8:0] exp1_q[$];

    always #5 CLK = ~CLK;

    gf180mcu_fd_sc_mcu9t5v0__sertx8 dut0 (
        .CLK(CLK), .RN(RN), .D(D0), .VALID(V0),
        .READY(READY0), .Q(Q0), .FRAME(FRAME0)
    );

    gf180mcu_fd_sc_mcu9t5v0__sertx8 #(
        .WIDTH(8), .LSB_FIRST(0), .PARITY_EN(1)
    ) dut1 (
        .CLK(CLK), .RN(RN), .D(D1), .VALID(V1),
        .READY(READY1), .Q(Q1), .FRAME(FRAME1)
    );

    // Falling-edge receivers: deserialize by FRAME and score each word.
    int         n0 = 0, hi0 = 0, run0 = 0, lastrun0 = 0;
    int         n1 = 0, hi1 = 0, run1 = 0, lastrun1 = 0;
    logic [7:0] w0 = 8'h00;
    logic [8:0] w1 = 9'h000;

    always @(negedge CLK) begin
        if (!RN) begin
            n0 = 0; run0 = 0;
        end else if (FRAME0) begin
            w0[n0] = Q0; n0++; hi0++; run0++;
            if (n0 == 8) begin
                n0 = 0;
                rx_checks++;
                if (exp0_q.size() == 0) begin
                    rx_errors++;
                    $display("FAIL rx0_extra_frame got %h required none", w0);
                end else begin
                    logic [7:0] e;
                    e = exp0_q.pop_front();
                    if (w0 !== e) begin
                        rx_errors++;
                        $display("FAIL rx0_word got %h required %h", w0, e);
                    end
                end
            end
        end else begin
            if (run0 != 0) lastrun0 = run0;
            run0 = 0;
            if (n0 != 0) begin
                rx_checks++; rx_errors++;
                $display("FAIL rx0_partial got %0d bits required 0", n0);
                n0 = 0;
            end
        end
    end

    always @(negedge CLK) begin
        if (!RN) begin
            n1 = 0; run1 = 0;
        end else if (FRAME1) begin
            if (n1 < 8) w1[7-n1] = Q1; else w1[8] = Q1;
            n1++; hi1++; run1++;
            if (n1 == 9) begin
                n1 = 0;
                rx_checks++;
                if (exp1_q.size() == 0) begin
                    rx_errors++;
                    $display("FAIL rx1_extra_frame got %h required none", w1);
                end else begin
                    logic [8:0] e;
                    e = exp1_q.pop_front();
                    if (w1 !== e) begin
                        rx_errors++;
                        $display("FAIL rx1_word got %h required %h", w1, e);
                    end
                end
            end
        end else begin
            if (run1 != 0) lastrun1 = run1;
            run1 = 0;
            if (n1 != 0) begin
                rx_checks++; rx_errors++;
                $display("FAIL rx1_partial got %0d bits required 0", n1);
                n1 = 0;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (READY0 !== 1'b1) begin errors++; $display("FAIL reset_ready0 got %b required 1", READY0); end
        checks++; if (Q0 !== 1'b0)     begin errors++; $display("FAIL reset_q0 got %b required 0", Q0); end
        checks++; if (FRAME0 !== 1'b0) begin errors++; $display("FAIL reset_frame0 got %b required 0", FRAME0); end
        checks++; if (READY1 !== 1'b1) begin errors++; $display("FAIL reset_ready1 got %b required 1", READY1); end
        checks++; if (Q1 !== 1'b0)     begin errors++; $display("FAIL reset_q1 got %b required 0", Q1); end
        checks++; if (FRAME1 !== 1'b0) begin errors++; $display("FAIL reset_frame1 got %b required 0", FRAME1); end
        repeat (2) tick();
        RN = 1'b1;
    endtask

    task automatic test_single();
        int base;
        base = hi0;
        D0 = 8'hA5; V0 = 1'b1; exp0_q.push_back(8'hA5);
        tick();
        V0 = 1'b0; D0 = 8'h5A;
        repeat (3) tick();
        checks++; if (READY0 !== 1'b0) begin errors++; $display("FAIL single_ready_mid got %b required 0", READY0); end
        repeat (5) tick();
        checks++; if (FRAME0 !== 1'b0) begin errors++; $display("FAIL single_frame_end got %b required 0", FRAME0); end
        checks++; if (READY0 !== 1'b1) begin errors++; $display("FAIL single_ready_end got %b required 1", READY0); end
        checks++; if (Q0 !== 1'b0)     begin errors++; $display("FAIL single_q_idle got %b required 0", Q0); end
        tick();
        checks++; if (hi0 - base != 8) begin errors++; $display("FAIL single_frame_len got %0d required 8", hi0 - base); end
        checks++; if (exp0_q.size() != 0) begin errors++; $display("FAIL single_pending got %0d required 0", exp0_q.size()); end
    endtask

    task automatic test_parity();
        int base;
        base = hi1;
        D1 = 8'h07; V1 = 1'b1; exp1_q.push_back(9'h107);
        tick();
        V1 = 1'b0; D1 = 8'hFF;
        repeat (7) tick();
        checks++; if (READY1 !== 1'b0) begin errors++; $display("FAIL par_ready_lastbit got %b required 0", READY1); end
        tick();
        checks++; if (READY1 !== 1'b1) begin errors++; $display("FAIL par_ready_par got %b required 1", READY1); end
        checks++; if (FRAME1 !== 1'b1) begin errors++; $display("FAIL par_frame_par got %b required 1", FRAME1); end
        checks++; if (Q1 !== 1'b1)     begin errors++; $display("FAIL par_q_par got %b required 1", Q1); end
        tick();
        checks++; if (FRAME1 !== 1'b0) begin errors++; $display("FAIL par_frame_end got %b required 0", FRAME1); end
        tick();
        checks++; if (hi1 - base != 9) begin errors++; $display("FAIL par_frame_len got %0d required 9", hi1 - base); end
        checks++; if (exp1_q.size() != 0) begin errors++; $display("FAIL par_pending got %0d required 0", exp1_q.size()); end
    endtask

    task automatic test_back_to_back();
        exp0_q.push_back(8'h3C); exp0_q.push_back(8'hFF); exp0_q.push_back(8'h00);
        for (int c = 0; c < 24; c++) begin
            if (c == 0)  begin D0 = 8'h3C; V0 = 1'b1; end
            if (c == 8)  D0 = 8'hFF;
            if (c == 16) D0 = 8'h00;
            if (c == 17) V0 = 1'b0;
            checks++;
            if (READY0 !== ((c % 8) == 0)) begin
                errors++;
                $display("FAIL b2b_ready cycle %0d got %b required %b", c, READY0, ((c % 8) == 0));
            end
            tick();
        end
        repeat (2) tick();
        checks++; if (FRAME0 !== 1'b0) begin errors++; $display("FAIL b2b_frame_end got %b required 0", FRAME0); end
        checks++; if (lastrun0 != 24) begin errors++; $display("FAIL b2b_run got %0d required 24", lastrun0); end
        checks++; if (exp0_q.size() != 0) begin errors++; $display("FAIL b2b_pending got %0d required 0", exp0_q.size()); end
    endtask

    task automatic test_parity_back_to_back();
        exp1_q.push_back(9'h107); exp1_q.push_back(9'h0C3);
        for (int c = 0; c < 18; c++) begin
            if (c == 0)  begin D1 = 8'h07; V1 = 1'b1; end
            if (c == 9)  D1 = 8'hC3;
            if (c == 10) V1 = 1'b0;
            checks++;
            if (READY1 !== ((c % 9) == 0)) begin
                errors++;
                $display("FAIL pb2b_ready cycle %0d got %b required %b", c, READY1, ((c % 9) == 0));
            end
            tick();
        end
        repeat (2) tick();
        checks++; if (lastrun1 != 18) begin errors++; $display("FAIL pb2b_run got %0d required 18", lastrun1); end
        checks++; if (exp1_q.size() != 0) begin errors++; $display("FAIL pb2b_pending got %0d required 0", exp1_q.size()); end
    endtask

    task automatic test_reset_midframe();
        int base;
        base = hi0;
        D0 = 8'hF0; V0 = 1'b1;
        tick();
        V0 = 1'b0;
        repeat (4) tick();
        RN = 1'b0;
        #1;
        checks++; if (Q0 !== 1'b0)     begin errors++; $display("FAIL rst_mid_q got %b required 0", Q0); end
        checks++; if (FRAME0 !== 1'b0) begin errors++; $display("FAIL rst_mid_frame got %b required 0", FRAME0); end
        checks++; if (READY0 !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b required 1", READY0); end
        tick();
        RN = 1'b1;
        D0 = 8'h81; V0 = 1'b1; exp0_q.push_back(8'h81);
        tick();
        V0 = 1'b0;
        repeat (9) tick();
        checks++; if (hi0 - base != 12) begin errors++; $display("FAIL rst_mid_bits got %0d required 12", hi0 - base); end
        checks++; if (exp0_q.size() != 0) begin errors++; $display("FAIL rst_mid_pending got %0d required 0", exp0_q.size()); end
    endtask

    task automatic test_ignore_midframe();
        int base;
        base = hi0;
        D0 = 8'hC6; V0 = 1'b1; exp0_q.push_back(8'hC6);
        tick();
        for (int c = 1; c < 8; c++) begin
            D0 = 8'($urandom);
            V0 = ((c % 2) == 1);
            checks++;
            if (READY0 !== 1'b0) begin errors++; $display("FAIL ign_ready cycle %0d got %b required 0", c, READY0); end
            tick();
        end
        V0 = 1'b0; D0 = 8'($urandom);
        repeat (4) tick();
        checks++; if (FRAME0 !== 1'b0) begin errors++; $display("FAIL ign_frame_end got %b required 0", FRAME0); end
        checks++; if (hi0 - base != 8) begin errors++; $display("FAIL ign_frame_len got %0d required 8", hi0 - base); end
        checks++; if (exp0_q.size() != 0) begin errors++; $display("FAIL ign_pending got %0d required 0", exp0_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_parity_back_to_back();
        test_reset_midframe();
        test_ignore_midframe();
        repeat (2) tick();
        checks += rx_checks;
        errors += rx_errors;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
